// File: rtl/popcnt_frame_acc_pkg.sv
// Shared types and default sizes for the popcount frame accumulator.
package popcnt_frame_acc_pkg;

  localparam int DEF_WI_SZ  = 32;
  localparam int DEF_ACC_SZ = 16;

  // ACC: summing beats of the current frame; OUT: holding a result for downstream
  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

// File: rtl/popcnt_frame_acc_cnt_ones.sv
// cnt_ones: combinational count of the set bits in a WI_SZ-bit word.
module cnt_ones #(
  parameter int WI_SZ = 32
) (
  input  logic [WI_SZ-1:0]         data,
  output logic [$clog2(WI_SZ):0]   count
);

  localparam int CNT_W = $clog2(WI_SZ) + 1;

  // Ripple sum of individual bits; synthesis folds this into an adder tree
  always_comb begin
    count = '0;
    for (int i = 0; i < WI_SZ; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/popcnt_frame_acc.sv
// popcnt_frame_acc: counts the ones in every beat of a frame and reports the
// frame total. Stage 1 registers the popcount of each accepted beat, stage 2
// accumulates it and hands the total to downstream with a valid/ready pair.
// Optional build macro POPCNT_ACC_SAT_EN: saturate the accumulator instead of
// wrapping it, and report the clamp on m_sat.
module popcnt_frame_acc
  import popcnt_frame_acc_pkg::*;
#(
  parameter int WI_SZ  = DEF_WI_SZ,
  parameter int ACC_SZ = DEF_ACC_SZ
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WI_SZ-1:0]  s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_SZ-1:0] m_count,
  output logic              m_sat
);

  localparam int PC_W = $clog2(WI_SZ) + 1;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_comb;
  logic [PC_W-1:0]   pc_q;
  logic              pc_last;
  logic              pc_vld;
  logic [ACC_SZ-1:0] acc;
  logic [ACC_SZ-1:0] acc_nxt;
  logic              beat_in;
  logic              frame_done;

  cnt_ones #(.WI_SZ(WI_SZ)) u_cnt_ones (
    .data  (s_data),
    .count (pc_comb)
  );

  // A last beat sitting in stage 1 or a pending result blocks the next frame
  assign s_ready    = (state == ACC) && !(pc_vld && pc_last);
  assign beat_in    = s_valid && s_ready;
  assign frame_done = (state == ACC) && pc_vld && pc_last;

`ifdef POPCNT_ACC_SAT_EN
  logic [ACC_SZ:0] sum_full;
  logic            ovf;
  logic            sat_q;

  assign sum_full = {1'b0, acc} + (ACC_SZ+1)'(pc_q);
  assign ovf      = sum_full[ACC_SZ];
  assign acc_nxt  = ovf ? '1 : sum_full[ACC_SZ-1:0];

  // Sticky overflow flag for the frame in progress, published with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      m_sat <= 1'b0;
    end else if ((state == ACC) && pc_vld) begin
      if (pc_last) begin
        m_sat <= sat_q | ovf;
        sat_q <= 1'b0;
      end else begin
        sat_q <= sat_q | ovf;
      end
    end
  end
`else
  assign acc_nxt = acc + ACC_SZ'(pc_q);
  assign m_sat   = 1'b0;
`endif

  // Stage 1: capture popcount and frame marker of every accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc_last <= 1'b0;
      pc_vld  <= 1'b0;
    end else begin
      pc_vld <= beat_in;
      if (beat_in) begin
        pc_q    <= pc_comb;
        pc_last <= s_last;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // FSM next state: close a frame into OUT, leave OUT on downstream handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (frame_done) state_nxt = OUT;
      OUT:     if (m_ready)    state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Stage 2: accumulate, and on the last beat move the total to the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      m_count <= '0;
      m_valid <= 1'b0;
    end else if ((state == ACC) && pc_vld) begin
      if (pc_last) begin
        m_count <= acc_nxt;
        m_valid <= 1'b1;
        acc     <= '0;
      end else begin
        acc <= acc_nxt;
      end
    end else if ((state == OUT) && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcnt_frame_acc.sv
// Directed bench for popcnt_frame_acc: a default-size instance and a narrow
// (ACC_SZ=6) instance for the overflow behaviour. Honors POPCNT_ACC_SAT_EN.
module tb_popcnt_frame_acc;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_sat;
  logic [31:0] s_data;
  logic [15:0] m_count;

  logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_sat;
  logic [31:0] b_s_data;
  logic [5:0]  b_m_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  popcnt_frame_acc #(.WI_SZ(32), .ACC_SZ(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_sat(m_sat)
  );

  popcnt_frame_acc #(.WI_SZ(32), .ACC_SZ(6)) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_count(b_m_count), .m_sat(b_m_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_count !== 16'd0) begin n_err++; $display("[TB] FAIL reset m_count: got %0d want 0", m_count); end
    n_cmp++; if (m_sat !== 1'b0) begin n_err++; $display("[TB] FAIL reset m_sat: got %b want 0", m_sat); end
    n_cmp++; if (b_m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset narrow m_valid: got %b want 0", b_m_valid); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_three_beat();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'hFFFF_FFFF; s_last = 1'b0; tick();
    s_data = 32'h0000_000F; tick();
    s_data = 32'h8000_0001; s_last = 1'b1; tick();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL three_beat early m_valid: got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL three_beat s_ready after last: got %b want 0", s_ready); end
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL three_beat m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_count !== 16'd38) begin n_err++; $display("[TB] FAIL three_beat m_count: got %0d want 38", m_count); end
    n_cmp++; if (m_sat !== 1'b0) begin n_err++; $display("[TB] FAIL three_beat m_sat: got %b want 0", m_sat); end
    tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL three_beat drained m_valid: got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL three_beat s_ready after drain: got %b want 1", s_ready); end
  endtask

  task automatic test_zero_frame();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'h0000_0000; s_last = 1'b1; tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL zero_frame m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_count !== 16'd0) begin n_err++; $display("[TB] FAIL zero_frame m_count: got %0d want 0", m_count); end
    n_cmp++; if (m_sat !== 1'b0) begin n_err++; $display("[TB] FAIL zero_frame m_sat: got %b want 0", m_sat); end
    tick();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h0000_00FF; s_last = 1'b1; tick();
    // keep offering a different frame; it must be ignored while blocked
    s_data = 32'hFFFF_FFFF;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL backpressure m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_count !== 16'd8) begin n_err++; $display("[TB] FAIL backpressure m_count: got %0d want 8", m_count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL backpressure hold m_valid cyc%0d: got %b want 1", i, m_valid); end
      n_cmp++; if (m_count !== 16'd8) begin n_err++; $display("[TB] FAIL backpressure hold m_count cyc%0d: got %0d want 8", i, m_count); end
      n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL backpressure hold s_ready cyc%0d: got %b want 0", i, s_ready); end
    end
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL backpressure release m_valid: got %b want 0", m_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL backpressure release s_ready: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL backpressure next m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_count !== 16'd32) begin n_err++; $display("[TB] FAIL backpressure next m_count: got %0d want 32", m_count); end
    m_ready = 1'b1; tick();
  endtask

  task automatic test_overflow();
    logic [5:0] exp_cnt;
    logic       exp_sat;
`ifdef POPCNT_ACC_SAT_EN
    exp_cnt = 6'd63; exp_sat = 1'b1;
`else
    exp_cnt = 6'd32; exp_sat = 1'b0;
`endif
    b_m_ready = 1'b1;
    b_s_valid = 1'b1; b_s_data = 32'hFFFF_FFFF; b_s_last = 1'b0; tick();
    tick();
    b_s_last = 1'b1; tick();
    b_s_valid = 1'b0; b_s_last = 1'b0;
    tick();
    n_cmp++; if (b_m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL overflow m_valid: got %b want 1", b_m_valid); end
    n_cmp++; if (b_m_count !== exp_cnt) begin n_err++; $display("[TB] FAIL overflow m_count: got %0d want %0d", b_m_count, exp_cnt); end
    n_cmp++; if (b_m_sat !== exp_sat) begin n_err++; $display("[TB] FAIL overflow m_sat: got %b want %b", b_m_sat, exp_sat); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'hFFFF_FFFF; s_last = 1'b0; tick();
    tick();
    s_valid = 1'b0;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    s_valid = 1'b1; s_data = 32'h0000_0003; s_last = 1'b1; tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL reset_mid m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_count !== 16'd2) begin n_err++; $display("[TB] FAIL reset_mid m_count: got %0d want 2", m_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [3];
    logic [15:0] exp_cnt [3];
    int acc_cyc [3];
    int bidx, ridx;
    logic take;
    pat[0] = 32'h0000_0001; pat[1] = 32'h0000_0003; pat[2] = 32'h0000_0007;
    exp_cnt[0] = 16'd1; exp_cnt[1] = 16'd2; exp_cnt[2] = 16'd3;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    bidx = 0; ridx = 0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      s_valid = (bidx < 3);
      s_data  = (bidx < 3) ? pat[bidx] : 32'h0;
      s_last  = 1'b1;
      #1;
      take = s_valid && s_ready;
      if (m_valid === 1'b1 && ridx < 3) begin
        n_cmp++; if (m_count !== exp_cnt[ridx]) begin n_err++; $display("[TB] FAIL b2b result%0d m_count: got %0d want %0d", ridx, m_count, exp_cnt[ridx]); end
        ridx++;
      end
      tick();
      if (take) begin
        acc_cyc[bidx] = cyc;
        bidx++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_cmp++; if (bidx != 3) begin n_err++; $display("[TB] FAIL b2b beats accepted: got %0d want 3", bidx); end
    n_cmp++; if (ridx != 3) begin n_err++; $display("[TB] FAIL b2b results seen: got %0d want 3", ridx); end
    n_cmp++; if (acc_cyc[1] - acc_cyc[0] != 3) begin n_err++; $display("[TB] FAIL b2b gap01: got %0d want 3", acc_cyc[1] - acc_cyc[0]); end
    n_cmp++; if (acc_cyc[2] - acc_cyc[1] != 3) begin n_err++; $display("[TB] FAIL b2b gap12: got %0d want 3", acc_cyc[2] - acc_cyc[1]); end
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_zero_frame();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
